// File: rtl/video_mode_ctrl_if.sv
// rtl/video_mode_ctrl_if.sv - request, status and timing bundle between control logic and video_mode_ctrl
interface video_mode_ctrl_if;
    logic        mode_req;
    logic [1:0]  mode_sel;
    logic        next_frame;
    logic        mode_ack;
    logic        mode_err;
    logic        busy;
    logic        video_mute;
    logic [1:0]  cur_mode;
    logic [1:0]  pclk_sel;
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;

    modport master (
        output mode_req, mode_sel, next_frame,
        input  mode_ack, mode_err, busy, video_mute, cur_mode, pclk_sel,
        input  h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end
    );

    modport slave (
        input  mode_req, mode_sel, next_frame,
        output mode_ack, mode_err, busy, video_mute, cur_mode, pclk_sel,
        output h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end
    );
endinterface

// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - HDMI video mode scheduler: mutes, swaps timing at a frame boundary, unmutes
module video_mode_ctrl #(
    parameter int MUTE_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic             hdmi_clk,
    input  logic             reset,
    video_mode_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_MUTE,
        S_APPLY,
        S_POST_MUTE,
        S_DONE
    } state_t;

    // Packed as h_total,h_sync,h_start,h_end,v_total,v_sync,v_start,v_end (MSB first)
    localparam logic [95:0] M0 = {12'd2199, 12'd43, 12'd189, 12'd2109,
                                  12'd1124, 12'd4,  12'd40,  12'd1120};
    localparam logic [95:0] M1 = {12'd1649, 12'd39, 12'd257, 12'd1537,
                                  12'd749,  12'd4,  12'd24,  12'd744};
    localparam logic [95:0] M2 = {12'd799,  12'd95, 12'd141, 12'd781,
                                  12'd524,  12'd1,  12'd34,  12'd514};

    function automatic logic [95:0] f_timing(input logic [1:0] mode);
        case (mode)
            2'd1:    return M1;
            2'd2:    return M2;
            default: return M0;
        endcase
    endfunction

    state_t      r_state,    w_state_nx;
    logic [3:0]  r_fcnt,     w_fcnt_nx;
    logic [22:0] r_tcnt,     w_tcnt_nx;
    logic [1:0]  r_mode_lat, w_mode_lat_nx;
    logic [1:0]  r_cur_mode, w_cur_mode_nx;
    logic [95:0] r_timing,   w_timing_nx;
    logic        r_ack,      w_ack_nx;
    logic        r_err,      w_err_nx;
    logic        r_busy,     w_busy_nx;
    logic        r_mute,     w_mute_nx;
    logic        w_fcnt_last;
    logic        w_timeout;

    assign w_fcnt_last = (r_fcnt == 4'(MUTE_FRAMES - 1));
    assign w_timeout   = (r_tcnt == 23'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nx    = r_state;
        w_fcnt_nx     = r_fcnt;
        w_mode_lat_nx = r_mode_lat;
        w_cur_mode_nx = r_cur_mode;
        w_timing_nx   = r_timing;
        w_ack_nx      = 1'b0;
        w_err_nx      = 1'b0;
        w_busy_nx     = r_busy;
        w_mute_nx     = r_mute;

        case (r_state)
            S_IDLE: begin
                if (bus.mode_req) begin
                    if (bus.mode_sel == 2'd3) begin
                        w_err_nx = 1'b1;
                    end else if (bus.mode_sel == r_cur_mode) begin
                        w_ack_nx = 1'b1;
                    end else begin
                        w_mode_lat_nx = bus.mode_sel;
                        w_fcnt_nx     = 4'd0;
                        w_busy_nx     = 1'b1;
                        w_mute_nx     = 1'b1;
                        w_state_nx    = S_PRE_MUTE;
                    end
                end
            end
            S_PRE_MUTE: begin
                if (bus.next_frame) begin
                    w_fcnt_nx = r_fcnt + 4'd1;
                end
                // Registers load on entry to APPLY so the new table is live during APPLY
                if ((bus.next_frame && w_fcnt_last) || (!bus.next_frame && w_timeout)) begin
                    w_state_nx    = S_APPLY;
                    w_fcnt_nx     = 4'd0;
                    w_timing_nx   = f_timing(r_mode_lat);
                    w_cur_mode_nx = r_mode_lat;
                    w_err_nx      = !bus.next_frame;
                end
            end
            S_APPLY: begin
                w_fcnt_nx  = 4'd0;
                w_state_nx = S_POST_MUTE;
            end
            S_POST_MUTE: begin
                if (bus.next_frame) begin
                    w_fcnt_nx = r_fcnt + 4'd1;
                end
                if ((bus.next_frame && w_fcnt_last) || (!bus.next_frame && w_timeout)) begin
                    w_state_nx = S_DONE;
                    w_fcnt_nx  = 4'd0;
                    w_ack_nx   = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_mute_nx  = 1'b0;
                    w_err_nx   = !bus.next_frame;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if ((w_state_nx != r_state) || bus.next_frame ||
            !((r_state == S_PRE_MUTE) || (r_state == S_POST_MUTE))) begin
            w_tcnt_nx = 23'd0;
        end else begin
            w_tcnt_nx = r_tcnt + 23'd1;
        end
    end

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fcnt     <= 4'd0;
            r_tcnt     <= 23'd0;
            r_mode_lat <= 2'd0;
            r_cur_mode <= 2'd0;
            r_timing   <= M0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_mute     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_fcnt     <= w_fcnt_nx;
            r_tcnt     <= w_tcnt_nx;
            r_mode_lat <= w_mode_lat_nx;
            r_cur_mode <= w_cur_mode_nx;
            r_timing   <= w_timing_nx;
            r_ack      <= w_ack_nx;
            r_err      <= w_err_nx;
            r_busy     <= w_busy_nx;
            r_mute     <= w_mute_nx;
        end
    end

    assign bus.mode_ack   = r_ack;
    assign bus.mode_err   = r_err;
    assign bus.busy       = r_busy;
    assign bus.video_mute = r_mute;
    assign bus.cur_mode   = r_cur_mode;
    assign bus.pclk_sel   = r_cur_mode;
    assign bus.h_total    = r_timing[95:84];
    assign bus.h_sync     = r_timing[83:72];
    assign bus.h_start    = r_timing[71:60];
    assign bus.h_end      = r_timing[59:48];
    assign bus.v_total    = r_timing[47:36];
    assign bus.v_sync     = r_timing[35:24];
    assign bus.v_start    = r_timing[23:12];
    assign bus.v_end      = r_timing[11:0];
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - scoreboard bench for video_mode_ctrl
module tb_video_mode_ctrl;
    localparam logic [95:0] T_M0 = {12'd2199, 12'd43, 12'd189, 12'd2109,
                                    12'd1124, 12'd4,  12'd40,  12'd1120};
    localparam logic [95:0] T_M1 = {12'd1649, 12'd39, 12'd257, 12'd1537,
                                    12'd749,  12'd4,  12'd24,  12'd744};
    localparam logic [95:0] T_M2 = {12'd799,  12'd95, 12'd141, 12'd781,
                                    12'd524,  12'd1,  12'd34,  12'd514};
    localparam logic [11:0] H0 = 12'd2199;
    localparam logic [11:0] H1 = 12'd1649;
    localparam logic [11:0] H2 = 12'd799;

    typedef struct {
        logic        ack;
        logic        err;
        logic [1:0]  mode;
        logic [11:0] h;
        int          cyc;
    } exp_t;

    logic hdmi_clk = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;
    logic mute_ok;
    int   c0;
    exp_t q_a[$];
    exp_t q_b[$];

    video_mode_ctrl_if if_a ();
    video_mode_ctrl_if if_b ();

    video_mode_ctrl #(.MUTE_FRAMES(2)) dut_a (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .bus      (if_a.slave)
    );

    video_mode_ctrl #(.MUTE_FRAMES(2), .TIMEOUT_CYCLES(64)) dut_b (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .bus      (if_b.slave)
    );

    wire [95:0] tim_a = {if_a.h_total, if_a.h_sync, if_a.h_start, if_a.h_end,
                         if_a.v_total, if_a.v_sync, if_a.v_start, if_a.v_end};
    wire [5:0]  st_a  = {if_a.cur_mode, if_a.pclk_sel, if_a.busy, if_a.video_mute};

    always #5 hdmi_clk = ~hdmi_clk;
    always @(posedge hdmi_clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge hdmi_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_a(input logic ack, input logic err, input logic [1:0] m,
                          input logic [11:0] h, input int c);
        exp_t e;
        e.ack = ack; e.err = err; e.mode = m; e.h = h; e.cyc = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic ack, input logic err, input logic [1:0] m,
                          input logic [11:0] h, input int c);
        exp_t e;
        e.ack = ack; e.err = err; e.mode = m; e.h = h; e.cyc = c;
        q_b.push_back(e);
    endtask

    task automatic req_a(input logic [1:0] sel);
        if_a.mode_sel = sel;
        if_a.mode_req = 1'b1;
        tick();
        if_a.mode_req = 1'b0;
    endtask

    task automatic pulse_a();
        if_a.next_frame = 1'b1;
        tick();
        if_a.next_frame = 1'b0;
    endtask

    always @(negedge hdmi_clk) begin : monitor
        exp_t e;
        if (if_a.mode_ack || if_a.mode_err) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected: ack=%0b err=%0b cyc=%0d expected no response",
                         if_a.mode_ack, if_a.mode_err, cyc);
            end else begin
                e = q_a.pop_front();
                if ({if_a.mode_ack, if_a.mode_err, if_a.cur_mode, if_a.pclk_sel, if_a.h_total} !==
                    {e.ack, e.err, e.mode, e.mode, e.h} || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL a_resp: got ack=%0b err=%0b mode=%0d pclk=%0d h_total=%0d cyc=%0d expected ack=%0b err=%0b mode=%0d h_total=%0d cyc=%0d",
                             if_a.mode_ack, if_a.mode_err, if_a.cur_mode, if_a.pclk_sel, if_a.h_total, cyc,
                             e.ack, e.err, e.mode, e.h, e.cyc);
                end
            end
        end
        if (if_b.mode_ack || if_b.mode_err) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: ack=%0b err=%0b cyc=%0d expected no response",
                         if_b.mode_ack, if_b.mode_err, cyc);
            end else begin
                e = q_b.pop_front();
                if ({if_b.mode_ack, if_b.mode_err, if_b.cur_mode, if_b.pclk_sel, if_b.h_total} !==
                    {e.ack, e.err, e.mode, e.mode, e.h} || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL b_resp: got ack=%0b err=%0b mode=%0d pclk=%0d h_total=%0d cyc=%0d expected ack=%0b err=%0b mode=%0d h_total=%0d cyc=%0d",
                             if_b.mode_ack, if_b.mode_err, if_b.cur_mode, if_b.pclk_sel, if_b.h_total, cyc,
                             e.ack, e.err, e.mode, e.h, e.cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_a.mode_req = 1'b0; if_a.mode_sel = 2'd0; if_a.next_frame = 1'b0;
        if_b.mode_req = 1'b0; if_b.mode_sel = 2'd0; if_b.next_frame = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;

        // Reset and idle
        tick(10);
        check("t1_timing", tim_a, T_M0);
        check("t1_status", {st_a, if_a.mode_ack, if_a.mode_err}, 8'h00);

        // Invalid mode and same-mode requests from mode 0
        push_a(1'b0, 1'b1, 2'd0, H0, cyc + 1);
        req_a(2'd3);
        check("t3_err_no_change", {st_a, tim_a}, {6'd0, T_M0});
        tick(2);
        push_a(1'b1, 1'b0, 2'd0, H0, cyc + 1);
        req_a(2'd0);
        check("t3_same_no_busy", st_a, 6'd0);
        tick(3);

        // Mode 1 with next_frame every 100 cycles; a mode 2 request mid-sequence is ignored
        req_a(2'd1);
        check("t2_accept", {if_a.busy, if_a.video_mute}, 2'b11);
        mute_ok = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            for (int k = 0; k < 99; k++) begin
                tick();
                if (!(if_a.busy && if_a.video_mute)) mute_ok = 1'b0;
            end
            if (p == 2) check("t2_pre_apply", tim_a, T_M0);
            if (p == 4) push_a(1'b1, 1'b0, 2'd1, H1, cyc + 1);
            pulse_a();
            if (p == 1) begin
                check("t2_hold_after_1st", tim_a, T_M0);
                req_a(2'd2);
            end
            if (p == 2) begin
                check("t2_apply_timing", tim_a, T_M1);
                check("t2_apply_mode", {if_a.cur_mode, if_a.pclk_sel}, 4'b0101);
            end
            if (p < 4 && !(if_a.busy && if_a.video_mute)) mute_ok = 1'b0;
        end
        check("t2_mute_held", mute_ok, 1'b1);
        check("t2_unmute", {if_a.busy, if_a.video_mute}, 2'b00);
        tick(3);
        check("t4_final_mode", {if_a.cur_mode, tim_a}, {2'd1, T_M1});

        // Same-mode and invalid requests from mode 1
        push_a(1'b1, 1'b0, 2'd1, H1, cyc + 1);
        req_a(2'd1);
        check("t3b_same_no_busy", {if_a.busy, if_a.video_mute}, 2'b00);
        tick(2);
        push_a(1'b0, 1'b1, 2'd1, H1, cyc + 1);
        req_a(2'd3);
        check("t3b_err_no_change", {st_a, tim_a}, {6'b010100, T_M1});
        tick(3);

        // Reset during POST_MUTE
        req_a(2'd2);
        for (int p = 0; p < 2; p++) begin
            tick(9);
            pulse_a();
        end
        check("t6_applied", tim_a, T_M2);
        tick(5);
        pulse_a();
        tick(3);
        reset = 1'b1;
        tick();
        check("t6_reset_timing", tim_a, T_M0);
        check("t6_reset_status", {st_a, if_a.mode_ack, if_a.mode_err}, 8'h00);
        reset = 1'b0;
        tick(3);
        pulse_a();
        tick(4);
        pulse_a();
        tick(5);
        check("t6_stays_idle", {st_a, tim_a}, {6'd0, T_M0});

        // Timeouts on the 64-cycle instance, no next_frame at all
        c0 = cyc;
        push_b(1'b0, 1'b1, 2'd2, H2, c0 + 65);
        push_b(1'b1, 1'b1, 2'd2, H2, c0 + 130);
        if_b.mode_sel = 2'd2;
        if_b.mode_req = 1'b1;
        tick();
        if_b.mode_req = 1'b0;
        check("t5_accept", {if_b.busy, if_b.video_mute}, 2'b11);
        tick(140);
        check("t5_final", {if_b.cur_mode, if_b.busy, if_b.video_mute, if_b.v_total}, {2'd2, 2'b00, 12'd524});

        tick(5);
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
